// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-side responder for the core's instruction/data bus.
// Four-phase handshake: the core raises Req with Wr/Addr/WData stable and
// holds it until Ack is seen; the responder raises Ack (with RData/Err valid)
// and holds it until Req drops, then lowers Ack and returns to IDLE. Dropping
// Req before Ack aborts the access with no side effects.
// Per-type wait states are counted in WAIT. Accesses at Addr >= DEPTH return
// Err instead of touching storage. Storage has no reset.
module mem_bus_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 192,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData,
    output logic              Ack,
    output logic              Err,
    output logic              Busy,
    output logic [1:0]        DbgState
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
    localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                mem_we;
    logic                in_range;
    logic [IDX_W-1:0]    mem_idx;
    logic [DATA_W-1:0]   mem_rdata;

    logic [DATA_W-1:0]   mem [DEPTH];

    // In-range addresses fit in IDX_W bits, so the low bits index storage.
    assign in_range  = ({1'b0, addr_q} < DEPTH_L);
    assign mem_idx   = addr_q[IDX_W-1:0];
    assign mem_rdata = mem[mem_idx];

    // Next-state and access decode; all held values default to their registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    wr_d    = Wr;
                    addr_d  = Addr;
                    wdata_d = WData;
                    cnt_d   = Wr ? WR_CNT : RD_CNT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!Req) begin
                    // Abort: leave storage, RData and Err as they were.
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                    if (in_range) begin
                        err_d = 1'b0;
                        if (wr_q) begin
                            mem_we = 1'b1;
                        end else begin
                            rdata_d = mem_rdata;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (!wr_q) begin
                            rdata_d = '0;
                        end
                    end
                end
            end
            S_ACK: begin
                if (!Req) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and response registers; Reset wins over any in-flight access.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Storage write port; unreset so contents survive Reset, blocked while Reset is high.
    always_ff @(posedge Clk) begin
        if (mem_we && !Reset) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    assign RData    = rdata_q;
    assign Ack      = ack_q;
    assign Err      = err_q;
    assign Busy     = (state_q != S_IDLE);
    assign DbgState = state_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances with different wait settings
// (default 2/1, zero 0/0, slow 3/3) share Clk and Reset. A behavioural model
// (storage array + last-response register per instance) predicts latency,
// RData and Err for every access.
module tb_mem_bus_responder;

  localparam int DEPTH = 192;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [3];
  logic        wr    [3];
  logic [7:0]  addr  [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];
  logic        busy  [3];
  logic [1:0]  dbg   [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] model_mem [3][256];
  bit          known     [3][256];
  logic [15:0] exp_rdata [3];
  logic [15:0] exp_q[$];

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_responder #(.RD_WAIT(2), .WR_WAIT(1)) u_def (
    .Clk(clk), .Reset(rst), .Req(req[0]), .Wr(wr[0]), .Addr(addr[0]), .WData(wdata[0]),
    .RData(rdata[0]), .Ack(ack[0]), .Err(err[0]), .Busy(busy[0]), .DbgState(dbg[0]));
  mem_bus_responder #(.RD_WAIT(0), .WR_WAIT(0)) u_zero (
    .Clk(clk), .Reset(rst), .Req(req[1]), .Wr(wr[1]), .Addr(addr[1]), .WData(wdata[1]),
    .RData(rdata[1]), .Ack(ack[1]), .Err(err[1]), .Busy(busy[1]), .DbgState(dbg[1]));
  mem_bus_responder #(.RD_WAIT(3), .WR_WAIT(3)) u_slow (
    .Clk(clk), .Reset(rst), .Req(req[2]), .Wr(wr[2]), .Addr(addr[2]), .WData(wdata[2]),
    .RData(rdata[2]), .Ack(ack[2]), .Err(err[2]), .Busy(busy[2]), .DbgState(dbg[2]));

  function automatic int rd_wait(input int d);
    return (d == 0) ? 2 : (d == 1) ? 0 : 3;
  endfunction

  function automatic int wr_wait(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  // reference model: expected latency (edges after the sampling edge), RData, Err
  task automatic model_access(input int d, input logic w, input logic [7:0] a, input logic [15:0] wd,
                              output int e_lat, output logic [15:0] e_rd, output logic e_err);
    e_lat = (w ? wr_wait(d) : rd_wait(d)) + 1;
    e_err = (int'(a) >= DEPTH);
    if (e_err) begin
      e_rd = w ? exp_rdata[d] : 16'h0000;
    end else if (w) begin
      e_rd = exp_rdata[d];
      model_mem[d][a] = wd;
      known[d][a] = 1'b1;
    end else begin
      e_rd = model_mem[d][a];
    end
    exp_rdata[d] = e_rd;
  endtask

  // driver: full four-phase access; called at a negedge, returns at a negedge in IDLE
  task automatic drive_access(input int d, input logic w, input logic [7:0] a, input logic [15:0] wd,
                              input int hold, output int lat, output int ack_cyc,
                              output logic [15:0] rd, output logic er, output bit busy_ok,
                              output bit stable_ok, output logic [2:0] post);
    bit seen = 1'b0;
    busy_ok = 1'b1;
    stable_ok = 1'b1;
    lat = -1;
    ack_cyc = 0;
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (t == 0) begin
        wr[d] = 1'($urandom_range(0, 1));
        addr[d] = 8'($urandom);
        wdata[d] = 16'($urandom);
      end
      if (ack[d] === 1'b1) begin
        lat = t;
        seen = 1'b1;
        break;
      end
      if (busy[d] !== 1'b1) busy_ok = 1'b0;
    end
    ack_cyc = cyc;
    rd = rdata[d];
    er = err[d];
    if (!seen) stable_ok = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack[d] !== 1'b1 || rdata[d] !== rd || err[d] !== er || busy[d] !== 1'b1) stable_ok = 1'b0;
    end
    req[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    post = {ack[d], busy[d], err[d]};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b1; wr[d] = 1'b1; addr[d] = 8'hFF; wdata[d] = 16'hFFFF;
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if ({ack[d], err[d], busy[d], rdata[d]} !== 19'h0) begin
          n_fail++;
          $display("FAIL reset_hold d%0d cyc%0d: ack/err/busy/rdata got %b/%b/%b/%h expected 0/0/0/0000",
                   d, c, ack[d], err[d], busy[d], rdata[d]);
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 8'h00; wdata[d] = 16'h0000;
      exp_rdata[d] = 16'h0000;
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, ac, el; logic [15:0] rd, erd; logic er, ee; bit bo, so; logic [2:0] post;
    model_access(0, 1'b1, 8'h10, 16'hBEEF, el, erd, ee);
    drive_access(0, 1'b1, 8'h10, 16'hBEEF, 1, lat, ac, rd, er, bo, so, post);
    n_checks++; if (lat !== el) begin n_fail++; $display("FAIL basic_wr_lat: got %0d expected %0d", lat, el); end
    n_checks++; if (er !== ee) begin n_fail++; $display("FAIL basic_wr_err: got %b expected %b", er, ee); end
    n_checks++; if (!bo || !so || post !== 3'b000) begin n_fail++;
      $display("FAIL basic_wr_hs: busy_ok %0d stable_ok %0d post %b expected 1 1 000", bo, so, post); end
    model_access(0, 1'b0, 8'h10, 16'h0000, el, erd, ee);
    drive_access(0, 1'b0, 8'h10, 16'h0000, 2, lat, ac, rd, er, bo, so, post);
    n_checks++; if (lat !== el) begin n_fail++; $display("FAIL basic_rd_lat: got %0d expected %0d", lat, el); end
    n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL basic_rd_data: got %h expected %h", rd, erd); end
    n_checks++; if (er !== ee) begin n_fail++; $display("FAIL basic_rd_err: got %b expected %b", er, ee); end
    n_checks++; if (!bo || !so || post !== 3'b000) begin n_fail++;
      $display("FAIL basic_rd_hs: busy_ok %0d stable_ok %0d post %b expected 1 1 000", bo, so, post); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, ac1, ac2, el1, el2; logic [15:0] rd, erd, v; logic er, ee; bit bo, so; logic [2:0] post;
    v = 16'($urandom);
    model_access(1, 1'b1, 8'h00, v, el1, erd, ee);
    drive_access(1, 1'b1, 8'h00, v, 0, lat1, ac1, rd, er, bo, so, post);
    model_access(1, 1'b0, 8'h00, 16'h0000, el2, erd, ee);
    drive_access(1, 1'b0, 8'h00, 16'h0000, 0, lat2, ac2, rd, er, bo, so, post);
    n_checks++; if (lat1 !== el1) begin n_fail++; $display("FAIL b2b_wr_lat: got %0d expected %0d", lat1, el1); end
    n_checks++; if (lat2 !== el2) begin n_fail++; $display("FAIL b2b_rd_lat: got %0d expected %0d", lat2, el2); end
    n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL b2b_rd_data: got %h expected %h", rd, erd); end
    n_checks++; if (ac2 - ac1 !== 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 3", ac2 - ac1); end
  endtask

  task automatic test_out_of_range;
    int lat, ac, el; logic [15:0] rd, erd; logic er, ee; bit bo, so; logic [2:0] post;
    model_access(0, 1'b1, 8'h08, 16'h0A0A, el, erd, ee);
    drive_access(0, 1'b1, 8'h08, 16'h0A0A, 0, lat, ac, rd, er, bo, so, post);
    model_access(0, 1'b0, 8'hC8, 16'h0000, el, erd, ee);
    drive_access(0, 1'b0, 8'hC8, 16'h0000, 1, lat, ac, rd, er, bo, so, post);
    n_checks++; if (er !== ee || rd !== erd) begin n_fail++;
      $display("FAIL oor_rd: err/rdata got %b/%h expected %b/%h", er, rd, ee, erd); end
    n_checks++; if (!so || post !== 3'b000) begin n_fail++;
      $display("FAIL oor_rd_hs: stable_ok %0d post %b expected 1 000", so, post); end
    model_access(0, 1'b1, 8'hC8, 16'h1234, el, erd, ee);
    drive_access(0, 1'b1, 8'hC8, 16'h1234, 0, lat, ac, rd, er, bo, so, post);
    n_checks++; if (er !== ee || rd !== erd || lat !== el) begin n_fail++;
      $display("FAIL oor_wr: err/rdata/lat got %b/%h/%0d expected %b/%h/%0d", er, rd, lat, ee, erd, el); end
    model_access(0, 1'b0, 8'h08, 16'h0000, el, erd, ee);
    drive_access(0, 1'b0, 8'h08, 16'h0000, 0, lat, ac, rd, er, bo, so, post);
    n_checks++; if (er !== ee || rd !== erd) begin n_fail++;
      $display("FAIL oor_alias_rd: err/rdata got %b/%h expected %b/%h", er, rd, ee, erd); end
  endtask

  task automatic test_abort;
    int lat, ac, el; logic [15:0] rd, erd; logic er, ee; bit bo, so; logic [2:0] post;
    model_access(2, 1'b1, 8'h20, 16'h1111, el, erd, ee);
    drive_access(2, 1'b1, 8'h20, 16'h1111, 0, lat, ac, rd, er, bo, so, post);
    model_access(2, 1'b0, 8'h20, 16'h0000, el, erd, ee);
    drive_access(2, 1'b0, 8'h20, 16'h0000, 0, lat, ac, rd, er, bo, so, post);
    req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 8'h20; wdata[2] = 16'h5555;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    n_checks++; if (busy[2] !== 1'b1 || ack[2] !== 1'b0) begin n_fail++;
      $display("FAIL abort_wait: busy/ack got %b/%b expected 1/0", busy[2], ack[2]); end
    req[2] = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++; if ({busy[2], ack[2], err[2]} !== 3'b000 || rdata[2] !== exp_rdata[2]) begin n_fail++;
      $display("FAIL abort_idle: busy/ack/err/rdata got %b/%b/%b/%h expected 0/0/0/%h",
               busy[2], ack[2], err[2], rdata[2], exp_rdata[2]); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      n_checks++; if (ack[2] !== 1'b0) begin n_fail++; $display("FAIL abort_no_ack c%0d: got %b expected 0", c, ack[2]); end
    end
    model_access(2, 1'b0, 8'h20, 16'h0000, el, erd, ee);
    drive_access(2, 1'b0, 8'h20, 16'h0000, 0, lat, ac, rd, er, bo, so, post);
    n_checks++; if (rd !== erd || lat !== el) begin n_fail++;
      $display("FAIL abort_rd: rdata/lat got %h/%0d expected %h/%0d", rd, lat, erd, el); end
  endtask

  task automatic test_reset_in_ack;
    int lat, ac, el; logic [15:0] rd, erd; logic er, ee; bit bo, so; logic [2:0] post; bit seen;
    model_access(0, 1'b1, 8'h30, 16'hBEEF, el, erd, ee);
    drive_access(0, 1'b1, 8'h30, 16'hBEEF, 0, lat, ac, rd, er, bo, so, post);
    model_access(0, 1'b0, 8'h30, 16'h0000, el, erd, ee);
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 8'h30;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); @(negedge clk);
      if (ack[0] === 1'b1) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen || rdata[0] !== erd) begin n_fail++;
      $display("FAIL rst_ack_pre: ack_seen %0d rdata %h expected 1 %h", seen, rdata[0], erd); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++; if ({ack[0], busy[0], err[0]} !== 3'b000 || rdata[0] !== 16'h0000) begin n_fail++;
      $display("FAIL rst_ack_post: ack/busy/err/rdata got %b/%b/%b/%h expected 0/0/0/0000",
               ack[0], busy[0], err[0], rdata[0]); end
    req[0] = 1'b0;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) exp_rdata[d] = 16'h0000;
    @(posedge clk); @(negedge clk);
    model_access(0, 1'b0, 8'h30, 16'h0000, el, erd, ee);
    drive_access(0, 1'b0, 8'h30, 16'h0000, 0, lat, ac, rd, er, bo, so, post);
    n_checks++; if (rd !== erd || er !== ee) begin n_fail++;
      $display("FAIL rst_ack_retain: rdata/err got %h/%b expected %h/%b", rd, er, erd, ee); end
  endtask

  task automatic test_random;
    int lat, ac, el, d, hold; logic [15:0] rd, erd, wd, exp_rd; logic er, ee, w; logic [7:0] a;
    bit bo, so; logic [2:0] post;
    logic [7:0] pool [8];
    for (int i = 0; i < 8; i++) pool[i] = 8'($urandom_range(0, DEPTH - 1));
    for (int n = 0; n < 60; n++) begin
      d = $urandom_range(0, 2);
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(DEPTH, 255)) : pool[$urandom_range(0, 7)];
      if (!w && int'(a) < DEPTH && !known[d][a]) w = 1'b1;
      wd = 16'($urandom);
      hold = $urandom_range(0, 2);
      model_access(d, w, a, wd, el, erd, ee);
      exp_q.push_back(erd);
      drive_access(d, w, a, wd, hold, lat, ac, rd, er, bo, so, post);
      exp_rd = exp_q.pop_front();
      n_checks++; if (lat !== el) begin n_fail++;
        $display("FAIL rnd_lat n%0d d%0d wr%b a%h: got %0d expected %0d", n, d, w, a, lat, el); end
      n_checks++; if (rd !== exp_rd) begin n_fail++;
        $display("FAIL rnd_rdata n%0d d%0d wr%b a%h: got %h expected %h", n, d, w, a, rd, exp_rd); end
      n_checks++; if (er !== ee) begin n_fail++;
        $display("FAIL rnd_err n%0d d%0d a%h: got %b expected %b", n, d, a, er, ee); end
      n_checks++; if (!bo || !so || post !== 3'b000) begin n_fail++;
        $display("FAIL rnd_hs n%0d d%0d: busy_ok %0d stable_ok %0d post %b expected 1 1 000", n, d, bo, so, post); end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 8'h00; wdata[d] = 16'h0000;
      exp_rdata[d] = 16'h0000;
      for (int i = 0; i < 256; i++) known[d][i] = 1'b0;
    end
    rst = 1'b1;
    test_reset;
    test_basic;
    test_back_to_back;
    test_out_of_range;
    test_abort;
    test_reset_in_ack;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
